// File: rtl/ram_pkg.sv
// Shared types and defaults for the clearable synchronous RAM.
// RAM_PARITY_EN adds the even-parity helper.
package ram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 9;
  localparam int PAR_MAX_W  = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

`ifdef RAM_PARITY_EN
  function automatic logic par_even(
    input logic [PAR_MAX_W-1:0] d
  );
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero,
// then reports ready. Owns the state, clear counter and busy flag.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // Next state: step the counter each clear cycle, leave after the last word
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    clr_addr  = clr_cnt_q;
    if (rst) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_we    = 1'b1;
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (&clr_cnt_q) state_d = READY;
        end
        READY: ;
        default: ;
      endcase
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with hardware clear after reset and a
// registered, write-first read. RAM_PARITY_EN adds stored even parity.
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_valid,
  output logic              busy
`ifdef RAM_PARITY_EN
  ,
  input  logic              par_inject,
  output logic              par_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              acc_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              rd_valid_q, rd_valid_d;
`ifdef RAM_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Word as it would be stored by a user write this cycle
  always_comb begin
`ifdef RAM_PARITY_EN
    wr_word = {par_even(PAR_MAX_W'(datain)) ^ par_inject, datain};
`else
    wr_word = datain;
`endif
  end

  // Array write port: clear sequencer has priority over user writes
  always_comb begin
    acc_ok    = !rst && !busy && en;
    mem_we    = 1'b0;
    mem_addr  = add;
    mem_wdata = wr_word;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end else if (acc_ok && write) begin
      mem_we = 1'b1;
    end
  end

  // Read path: a same-cycle write to this address wins
  always_comb begin
    dataout_d  = dataout_q;
    rd_valid_d = 1'b0;
    rd_word    = '0;
`ifdef RAM_PARITY_EN
    par_err_d  = par_err_q;
`endif
    if (acc_ok && read) begin
      rd_word    = write ? wr_word : mem[add];
      dataout_d  = rd_word[DATA_W-1:0];
      rd_valid_d = 1'b1;
`ifdef RAM_PARITY_EN
      par_err_d  = rd_word[DATA_W] ^
                   par_even(PAR_MAX_W'(rd_word[DATA_W-1:0]));
`endif
    end
  end

  // Storage array, no reset: contents zeroed by the clear sequencer
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Read output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      dataout_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef RAM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      dataout_q  <= dataout_d;
      rd_valid_q <= rd_valid_d;
`ifdef RAM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign dataout  = dataout_q;
  assign rd_valid = rd_valid_q;
`ifdef RAM_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule
